// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Copies `len` consecutive words from src_addr to dst_addr over a single
//   request/response memory port. Each word is read, its response is
//   captured, and it is written back out before the next read starts. This
//   gives strict ascending, word-at-a-time semantics for overlapping regions.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   start             copy request, only looked at while idle
//   src_addr/dst_addr first source / destination word address
//   len               number of words (0 = finish immediately, no traffic)
//   busy, done        busy outside IDLE; done is a one-cycle completion pulse
//   mem_req_*         request channel (valid/ready handshake, write byte mask,
//                     mask 0 = read)
//   mem_resp_*        read response, one per accepted read
//   checksum          only with MEM_COPY_CHECKSUM_EN: the sum of the words
//                     copied, modulo 2^CPU_WIDTH
//
// Configuration macro: MEM_COPY_CHECKSUM_EN (adds the checksum output)
// All outputs are registered and computed from the next state.

`ifndef CPU_INST_BITS
`define CPU_INST_BITS 32
`endif
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif
`ifndef ceilLog2
`define ceilLog2(x) ($clog2(x))
`endif

module mem_copy_engine #(
    parameter int CPU_WIDTH      = `CPU_INST_BITS,
    parameter int WORD_ADDR_BITS = `CPU_ADDR_BITS - `ceilLog2(`CPU_INST_BITS/8),
    parameter int LEN_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WORD_ADDR_BITS-1:0] src_addr,
    input  logic [WORD_ADDR_BITS-1:0] dst_addr,
    input  logic [LEN_BITS-1:0]       len,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
    output logic [CPU_WIDTH-1:0]      mem_req_data,
    output logic [3:0]                mem_req_write,
`ifdef MEM_COPY_CHECKSUM_EN
    output logic [CPU_WIDTH-1:0]      checksum,
`endif
    input  logic                      mem_resp_valid,
    input  logic [CPU_WIDTH-1:0]      mem_resp_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        FINISH
    } state_t;

    state_t                    state_q, state_d;
    logic [WORD_ADDR_BITS-1:0] src_q, src_d;
    logic [WORD_ADDR_BITS-1:0] dst_q, dst_d;
    logic [LEN_BITS-1:0]       len_q, len_d;
    logic [LEN_BITS-1:0]       count_q, count_d;
    logic [LEN_BITS-1:0]       next_count;
    logic [WORD_ADDR_BITS-1:0] addr_q, addr_d;
    logic [CPU_WIDTH-1:0]      data_q, data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      valid_q, valid_d;
    logic [3:0]                write_q, write_d;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [CPU_WIDTH-1:0]      csum_q, csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        count_d    = count_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        next_count = count_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MEM_COPY_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (len != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len;
                        count_d = '0;
                        addr_d  = src_addr;
                        state_d = RD_REQ;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            // Address is already registered, so it stays put while stalled.
            RD_REQ: begin
                if (mem_req_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = mem_resp_data;
                    addr_d  = dst_q + WORD_ADDR_BITS'(count_q);
`ifdef MEM_COPY_CHECKSUM_EN
                    csum_d  = csum_q + mem_resp_data;
`endif
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_req_ready) begin
                    count_d = next_count;
                    if (next_count == len_q) begin
                        state_d = FINISH;
                    end else begin
                        // Address arithmetic wraps naturally at WORD_ADDR_BITS.
                        addr_d  = src_q + WORD_ADDR_BITS'(next_count);
                        state_d = RD_REQ;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are a pure decode of the state being entered.
        valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
        write_d = (state_d == WR_REQ) ? 4'hF : 4'h0;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            write_q <= 4'h0;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            write_q <= write_d;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
        // Operand and data registers are only meaningful while busy, so
        // they are left out of reset.
        src_q  <= src_d;
        dst_q  <= dst_d;
        len_q  <= len_d;
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_req_valid = valid_q;
    assign mem_req_write = write_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_data  = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum      = csum_q;
`endif

endmodule
